// File: rtl/ascii_fmt_pkg.sv
// Shared types and character constants for the ASCII report formatter.
package ascii_fmt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_LABEL,
      ST_COLON,
      ST_DIGIT,
      ST_SEP,
      ST_EOL_CR,
      ST_EOL_LF
   } fmt_state_t;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_COLON = 8'h3A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_QMARK = 8'h3F;
   localparam logic [7:0] CH_ZERO  = 8'h30;

   function automatic int fmt_line_len(input int n_digits, input int group,
                                       input int label_len, input int crlf);
      return 1 + label_len + 1 + n_digits + (n_digits / group - 1) + ((crlf != 0) ? 2 : 1);
   endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// One BCD nibble to its ASCII character; non-decimal nibbles render as '?'.
module bcd_to_ascii
   import ascii_fmt_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       suppress,
   output logic [7:0] ascii
);

   always_comb begin
      if (digit > 4'd9)
         ascii = CH_QMARK;
      else if (suppress && digit == 4'd0)
         ascii = CH_SPACE;
      else
         ascii = CH_ZERO + {4'd0, digit};
   end

endmodule

// File: rtl/ascii_report_fmt.sv
// Formats a packed BCD value as " <LABEL>:dd:dd:dd<EOL>" with a valid/ready byte stream.
// Leading-zero suppression is compiled in when ASCII_FMT_ZSUPP_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start, out_valid low
// LEAD     | presenting the leading space
// LABEL    | presenting label characters, MSB character first
// COLON    | presenting the fixed ':' after the label
// DIGIT    | presenting one digit of the captured value
// SEP      | presenting the group separator
// EOL_CR   | presenting CR (CRLF builds only)
// EOL_LF   | presenting LF, transfer ends the line
module ascii_report_fmt
   import ascii_fmt_pkg::*;
#(
   parameter int          N_DIGITS  = 6,
   parameter int          GROUP     = 2,
   parameter int          LABEL_LEN = 4,
   parameter logic [63:0] LABEL     = "TIME",
   parameter logic [7:0]  SEP       = 8'h3A,
   parameter bit          CRLF      = 1'b0
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*N_DIGITS-1:0] bcd_data,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);

   // label left-justified so the next character is always the top byte
   localparam logic [63:0] LBL_INIT = LABEL << (8 * (8 - LABEL_LEN));

   fmt_state_t            state;
   logic [4*N_DIGITS-1:0] bcd_sh;
   logic [63:0]           lbl_sh;
   logic [3:0]            lbl_idx;
   logic [4:0]            dig_idx;
   logic [4:0]            grp_cnt;
   logic                  xfer;
   logic [3:0]            top_nib;
   logic                  dig_supp;
   logic [7:0]            dig_char;
   logic [7:0]            sep_char;

   assign xfer    = out_valid && out_ready;
   assign top_nib = bcd_sh[4*N_DIGITS-1 -: 4];

`ifdef ASCII_FMT_ZSUPP_EN
   logic       zs_active;
   logic [4:0] dig_idx_nxt;
   logic       next_last;
   logic       load_dig;

   always_comb begin
      dig_idx_nxt = (state == ST_COLON) ? 5'd0 : dig_idx + 5'd1;
      next_last   = (dig_idx_nxt == 5'(N_DIGITS - 1));
      dig_supp    = zs_active && !next_last;
      sep_char    = zs_active ? CH_SPACE : SEP;
      load_dig    = xfer && ((state == ST_COLON) || (state == ST_SEP) ||
                    (state == ST_DIGIT && dig_idx != 5'(N_DIGITS - 1) &&
                     grp_cnt != 5'(GROUP - 1)));
   end

   // suppression stays on until a nonzero nibble (including > 9) has been loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         zs_active <= 1'b0;
      else if (state == ST_IDLE && start)
         zs_active <= 1'b1;
      else if (load_dig)
         zs_active <= zs_active && (top_nib == 4'd0);
   end
`else
   assign dig_supp = 1'b0;
   assign sep_char = SEP;
`endif

   bcd_to_ascii u_conv (
      .digit    (top_nib),
      .suppress (dig_supp),
      .ascii    (dig_char)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         bcd_sh    <= '0;
         lbl_sh    <= '0;
         lbl_idx   <= 4'd0;
         dig_idx   <= 5'd0;
         grp_cnt   <= 5'd0;
      end else begin
         done    <= 1'b0;
         overrun <= 1'b0;
         if (state == ST_IDLE) begin
            if (start) begin
               bcd_sh    <= bcd_data;
               lbl_sh    <= LBL_INIT;
               lbl_idx   <= 4'd0;
               dig_idx   <= 5'd0;
               grp_cnt   <= 5'd0;
               state     <= ST_LEAD;
               out_data  <= CH_SPACE;
               out_valid <= 1'b1;
               busy      <= 1'b1;
            end
         end else begin
            if (start)
               overrun <= 1'b1;
            if (xfer) begin
               case (state)
                  ST_LEAD: begin
                     if (LABEL_LEN > 0) begin
                        state    <= ST_LABEL;
                        out_data <= lbl_sh[63:56];
                        lbl_sh   <= lbl_sh << 8;
                     end else begin
                        state    <= ST_COLON;
                        out_data <= CH_COLON;
                     end
                  end
                  ST_LABEL: begin
                     if (lbl_idx == 4'(LABEL_LEN - 1)) begin
                        state    <= ST_COLON;
                        out_data <= CH_COLON;
                     end else begin
                        lbl_idx  <= lbl_idx + 4'd1;
                        out_data <= lbl_sh[63:56];
                        lbl_sh   <= lbl_sh << 8;
                     end
                  end
                  ST_COLON: begin
                     state    <= ST_DIGIT;
                     dig_idx  <= 5'd0;
                     grp_cnt  <= 5'd0;
                     out_data <= dig_char;
                     bcd_sh   <= bcd_sh << 4;
                  end
                  ST_DIGIT: begin
                     if (dig_idx == 5'(N_DIGITS - 1)) begin
                        if (CRLF) begin
                           state    <= ST_EOL_CR;
                           out_data <= CH_CR;
                        end else begin
                           state    <= ST_EOL_LF;
                           out_data <= CH_LF;
                        end
                     end else if (grp_cnt == 5'(GROUP - 1)) begin
                        state    <= ST_SEP;
                        grp_cnt  <= 5'd0;
                        out_data <= sep_char;
                     end else begin
                        dig_idx  <= dig_idx + 5'd1;
                        grp_cnt  <= grp_cnt + 5'd1;
                        out_data <= dig_char;
                        bcd_sh   <= bcd_sh << 4;
                     end
                  end
                  ST_SEP: begin
                     state    <= ST_DIGIT;
                     dig_idx  <= dig_idx + 5'd1;
                     out_data <= dig_char;
                     bcd_sh   <= bcd_sh << 4;
                  end
                  ST_EOL_CR: begin
                     state    <= ST_EOL_LF;
                     out_data <= CH_LF;
                  end
                  ST_EOL_LF: begin
                     state     <= ST_IDLE;
                     out_data  <= 8'h00;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ascii_report_fmt.sv
// Directed bench: default-config formatter plus a 4-digit, unlabelled CRLF variant.
module tb_ascii_report_fmt;
   import ascii_fmt_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic [23:0] a_bcd = '0;
   logic [15:0] b_bcd = '0;
   logic        sel = 1'b0;

   logic [7:0] a_data, b_data, o_data;
   logic       a_valid, a_busy, a_done, a_ovr;
   logic       b_valid, b_busy, b_done, b_ovr;
   logic       o_valid, o_busy, o_done, o_ovr;

   ascii_report_fmt dut_a (
      .clk(clk), .rst(rst), .start(start), .bcd_data(a_bcd),
      .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
      .busy(a_busy), .done(a_done), .overrun(a_ovr)
   );

   ascii_report_fmt #(
      .N_DIGITS(4), .GROUP(4), .LABEL_LEN(0), .LABEL(64'h0), .SEP(8'h3A), .CRLF(1'b1)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start), .bcd_data(b_bcd),
      .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
      .busy(b_busy), .done(b_done), .overrun(b_ovr)
   );

   always #5 clk = ~clk;

   always_comb begin
      o_data  = sel ? b_data  : a_data;
      o_valid = sel ? b_valid : a_valid;
      o_busy  = sel ? b_busy  : a_busy;
      o_done  = sel ? b_done  : a_done;
      o_ovr   = sel ? b_ovr   : a_ovr;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
      n_cmp++;
      if (got_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got_v, exp_v);
      end
   endtask

   logic [127:0] got;
   int           nbytes, ndone, novr, cyc_done, last_xfer, unstable;
   logic         first_valid, first_busy, busy_at_done;
   logic [7:0]   first_data;
   logic [15:0]  lfsr = 16'hACE1;

   task automatic do_start(input logic [23:0] da, input logic [15:0] db);
      for (int i = 0; i < 100 && (a_busy || b_busy); i++) @(negedge clk);
      chk_eq("idle_before_start", {a_busy, b_busy}, 0);
      a_bcd = da;
      b_bcd = db;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // collects the selected DUT's byte stream until two cycles past done
   task automatic capture(input bit rnd, input int inj_at, input logic [23:0] inj_bcd);
      logic       hold;
      logic [7:0] held;
      logic       r;
      hold = 1'b0;
      held = 8'h00;
      got = '0; nbytes = 0; ndone = 0; novr = 0;
      cyc_done = -1; last_xfer = -1; unstable = 0; busy_at_done = 1'b1;
      first_valid = o_valid; first_busy = o_busy; first_data = o_data;
      for (int k = 0; k < 400; k++) begin
         if (k > 0) @(negedge clk);
         if (hold && (o_valid !== 1'b1 || o_data !== held)) unstable++;
         if (o_ovr) novr++;
         if (o_done) begin
            ndone++;
            if (cyc_done < 0) begin
               cyc_done = k;
               busy_at_done = o_busy;
            end
         end
         if (cyc_done >= 0 && k >= cyc_done + 2) break;
         start = (k == inj_at);
         if (k == inj_at) a_bcd = inj_bcd;
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         r = rnd ? lfsr[0] : 1'b1;
         out_ready = r;
         if (o_valid && r) begin
            got = {got[119:0], o_data};
            nbytes++;
            last_xfer = k;
            hold = 1'b0;
         end else begin
            hold = o_valid;
            held = o_data;
         end
      end
      start = 1'b0;
   endtask

   logic [127:0] exp_line;

   initial begin
      repeat (3) @(negedge clk);
      chk_eq("reset_outputs", {a_data, a_valid, a_busy, a_done, a_ovr}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_eq("idle_no_valid", {a_valid, a_busy}, 0);

      // default line, ready held high
      sel = 1'b0;
      out_ready = 1'b1;
      do_start(24'h123456, 16'h0);
      capture(1'b0, -1, 24'h0);
      chk_eq("first_cycle", {first_valid, first_busy, first_data}, {1'b1, 1'b1, 8'h20});
      chk_eq("line_123456", got, {" TIME:12:34:56", 8'h0A});
      chk_eq("len_default", nbytes, fmt_line_len(6, 2, 4, 0));
      chk_eq("last_xfer_cycle", last_xfer, 14);
      chk_eq("done_cycle", cyc_done, 15);
      chk_eq("done_count", ndone, 1);
      chk_eq("busy_at_done", busy_at_done, 0);

      // same line with back-pressure
      do_start(24'h123456, 16'h0);
      capture(1'b1, -1, 24'h0);
      chk_eq("line_bp", got, {" TIME:12:34:56", 8'h0A});
      chk_eq("len_bp", nbytes, 15);
      chk_eq("stable_under_bp", unstable, 0);
      chk_eq("done_gap_bp", cyc_done - last_xfer, 1);

      // non-decimal nibble
      out_ready = 1'b1;
      do_start(24'h12A456, 16'h0);
      capture(1'b0, -1, 24'h0);
      chk_eq("line_12A456", got, {" TIME:12:?4:56", 8'h0A});

      // leading zeros
      do_start(24'h000305, 16'h0);
      capture(1'b0, -1, 24'h0);
`ifdef ASCII_FMT_ZSUPP_EN
      exp_line = {" TIME:    3:05", 8'h0A};
`else
      exp_line = {" TIME:00:03:05", 8'h0A};
`endif
      chk_eq("line_000305", got, exp_line);

      do_start(24'h000000, 16'h0);
      capture(1'b1, -1, 24'h0);
`ifdef ASCII_FMT_ZSUPP_EN
      exp_line = {" TIME:       0", 8'h0A};
`else
      exp_line = {" TIME:00:00:00", 8'h0A};
`endif
      chk_eq("line_zero", got, exp_line);
      chk_eq("len_zero", nbytes, 15);

      // start repeated mid-line with new data on the input
      out_ready = 1'b1;
      do_start(24'h123456, 16'h0);
      capture(1'b0, 5, 24'h999999);
      chk_eq("line_overrun", got, {" TIME:12:34:56", 8'h0A});
      chk_eq("overrun_count", novr, 1);
      chk_eq("done_count_ovr", ndone, 1);
      chk_eq("no_second_line", {o_valid, o_busy}, 0);

      // small unlabelled CRLF variant
      sel = 1'b1;
      out_ready = 1'b1;
      do_start(24'h0, 16'h0987);
      capture(1'b0, -1, 24'h0);
`ifdef ASCII_FMT_ZSUPP_EN
      exp_line = {" : 987", 8'h0D, 8'h0A};
`else
      exp_line = {" :0987", 8'h0D, 8'h0A};
`endif
      chk_eq("line_b_0987", got, exp_line);
      chk_eq("len_b", nbytes, fmt_line_len(4, 4, 0, 1));
      chk_eq("done_cycle_b", cyc_done, 8);

      // reset in the middle of a line
      do_start(24'h0, 16'h0987);
      @(negedge clk);
      @(negedge clk);
      chk_eq("b_midline_busy", {b_valid, b_busy}, 2'b11);
      rst = 1'b1;
      #1;
      chk_eq("reset_midline", {b_data, b_valid, b_busy, b_done, b_ovr}, 0);
      @(negedge clk);
      chk_eq("reset_held", {b_data, b_valid, b_busy, b_done, b_ovr, a_valid, a_busy}, 0);
      rst = 1'b0;
      @(negedge clk);
      do_start(24'h0, 16'h0042);
      capture(1'b0, -1, 24'h0);
`ifdef ASCII_FMT_ZSUPP_EN
      exp_line = {" :  42", 8'h0D, 8'h0A};
`else
      exp_line = {" :0042", 8'h0D, 8'h0A};
`endif
      chk_eq("line_b_after_reset", got, exp_line);
      chk_eq("done_count_b", ndone, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000");
      $fatal(1, "timeout");
   end

endmodule
